// File: rtl/traffic_ctrl_param.sv
// Highway / country-road junction controller with a tick prescaler, demand-driven
// country-road service and a night flashing mode.
module traffic_ctrl_param #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned HW_GREEN_T = 25,
  parameter int unsigned CT_GREEN_T = 10,
  parameter int unsigned YEL_T      = 3,
  parameter int unsigned TW         = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car,
  input  logic          night,
  output logic [1:0]    hw_color,
  output logic [1:0]    ct_color,
  output logic [TW-1:0] hw_time,
  output logic [TW-1:0] ct_time,
  output logic [2:0]    state_now
);

  localparam logic [2:0] HwGreen  = 3'b000;
  localparam logic [2:0] HwYellow = 3'b001;
  localparam logic [2:0] CtGreen  = 3'b010;
  localparam logic [2:0] CtYellow = 3'b011;
  localparam logic [2:0] Night    = 3'b100;

  localparam logic [1:0] ColRed = 2'b00;
  localparam logic [1:0] ColYel = 2'b01;
  localparam logic [1:0] ColGrn = 2'b10;
  localparam logic [1:0] ColOff = 2'b11;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HwLoad  = TW'(HW_GREEN_T - 1);
  localparam logic [TW-1:0] CtLoad  = TW'(CT_GREEN_T - 1);
  localparam logic [TW-1:0] YelLoad = TW'(YEL_T - 1);
  localparam logic [TW-1:0] YelAdd  = TW'(YEL_T);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          car_q, car_d;
  logic          flash_q, flash_d;
  logic          tick;

  assign tick = (presc_q == PresMax);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    car_d   = car_q | (car & (state_q != CtGreen));
    if (tick) begin
      case (state_q)
        HwGreen: begin
          if (night) begin
            state_d = Night;
            cnt_d   = '0;
            flash_d = 1'b1;
            car_d   = 1'b0;
          end else if (cnt_q == '0) begin
            // With no demand the counter simply parks at zero.
            if (car_q) begin
              state_d = HwYellow;
              cnt_d   = YelLoad;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HwYellow: begin
          if (cnt_q == '0) begin
            state_d = CtGreen;
            cnt_d   = CtLoad;
            car_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CtGreen: begin
          if (cnt_q == '0) begin
            state_d = CtYellow;
            cnt_d   = YelLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CtYellow: begin
          if (cnt_q == '0) begin
            state_d = HwGreen;
            cnt_d   = HwLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        Night: begin
          flash_d = ~flash_q;
          if (!night) begin
            state_d = HwGreen;
            cnt_d   = HwLoad;
          end
        end
        default: begin
          state_d = HwGreen;
          cnt_d   = HwLoad;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      state_q <= HwGreen;
      cnt_q   <= HwLoad;
      car_q   <= 1'b0;
      flash_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      car_q   <= car_d;
      flash_q <= flash_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    hw_color  = ColRed;
    ct_color  = ColRed;
    hw_time   = cnt_q;
    ct_time   = cnt_q;
    state_now = state_q;
    case (state_q)
      HwGreen: begin
        hw_color = ColGrn;
        ct_time  = cnt_q + YelAdd;
      end
      HwYellow: hw_color = ColYel;
      CtGreen: begin
        ct_color = ColGrn;
        hw_time  = cnt_q + YelAdd;
      end
      CtYellow: ct_color = ColYel;
      Night: begin
        hw_color = flash_q ? ColYel : ColOff;
        ct_color = flash_q ? ColYel : ColOff;
        hw_time  = '0;
        ct_time  = '0;
      end
      default: begin
        hw_color = ColRed;
        ct_color = ColRed;
      end
    endcase
  end

endmodule
